// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared state encoding, flag positions and width-derived
// constants for the sequential floating-point multiplier.
package fp_mul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      NORM,
      RND,
      DONE
   } state_e;

   // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Exponent bias for an expW-bit exponent field
   function automatic int biasOf(input int expW);
      return (1 << (expW - 1)) - 1;
   endfunction

   // All-ones exponent pattern, right-aligned in 64 bits
   function automatic logic [63:0] expOnesOf(input int expW);
      return (64'd1 << expW) - 64'd1;
   endfunction

   // Canonical quiet NaN {0, all-ones exp, 1 followed by zeros}, right-aligned
   function automatic logic [63:0] qnanOf(input int expW, input int manW);
      return (expOnesOf(expW) << manW) | (64'd1 << (manW - 1));
   endfunction

endpackage

// File: rtl/fp_classify.sv
// fp_classify: decodes one operand's exponent and fraction into the
// zero (denormals flushed), infinity and NaN classes.
module fp_classify
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W-1:0] exp_i,
   input  logic [MAN_W-1:0] frac_i,
   output logic             isZero_o,
   output logic             isInf_o,
   output logic             isNan_o
);

   localparam logic [63:0] ONES64 = expOnesOf(EXP_W);

   logic expOnes;

   // A zero exponent covers both true zero and denormals, which are flushed
   assign expOnes  = (exp_i == ONES64[EXP_W-1:0]);
   assign isZero_o = (exp_i == '0);
   assign isInf_o  = expOnes & (frac_i == '0);
   assign isNan_o  = expOnes & (frac_i != '0);

endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754 style multiplier with a shift-add
// significand datapath, FTZ inputs and exception flags.
// Optional feature macro: FP_MUL_RNE_EN selects round-to-nearest-even;
// without it the result is truncated toward zero.
module fp_mul_seq
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_result,
   output logic [3:0]             out_flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int PW = 2 * SW;
   localparam int XW = EXP_W + 2;
   localparam int CW = $clog2(MAN_W + 1);

   localparam logic [63:0]          QNAN64   = qnanOf(EXP_W, MAN_W);
   localparam logic [63:0]          ONES64   = expOnesOf(EXP_W);
   localparam logic signed [XW-1:0] BIAS_X   = XW'(biasOf(EXP_W));
   localparam logic signed [XW-1:0] MAXEXP_X = XW'(ONES64[EXP_W-1:0]);
   localparam logic signed [XW-1:0] ONE_X    = XW'(1);
   localparam logic signed [XW-1:0] ZERO_X   = '0;

   state_e                  state_q, state_d;
   logic                    sign_q, sign_d;
   logic signed [XW-1:0]    exp_q, exp_d;
   logic [PW-1:0]           acc_q, acc_d;
   logic [PW-1:0]           mcand_q, mcand_d;
   logic [SW-1:0]           mplier_q, mplier_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [MAN_W-1:0]        man_q, man_d;
   logic                    guard_q, guard_d;
   logic                    sticky_q, sticky_d;
   logic [W-1:0]            result_q, result_d;
   logic [3:0]              flags_q, flags_d;

   logic                    aZero, aInf, aNan, bZero, bInf, bNan;
   logic                    signX;
   logic [SW-1:0]           sigA, sigB;
   logic [EXP_W-1:0]        expA, expB;
   logic                    roundUp;
   logic [MAN_W:0]          manSum;
   logic signed [XW-1:0]    expR;

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uClassA (
      .exp_i    (expA),
      .frac_i   (in_a[MAN_W-1:0]),
      .isZero_o (aZero),
      .isInf_o  (aInf),
      .isNan_o  (aNan)
   );

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uClassB (
      .exp_i    (expB),
      .frac_i   (in_b[MAN_W-1:0]),
      .isZero_o (bZero),
      .isInf_o  (bInf),
      .isNan_o  (bNan)
   );

   // Operand field split and hidden-bit restoration
   assign expA  = in_a[W-2:MAN_W];
   assign expB  = in_b[W-2:MAN_W];
   assign sigA  = {1'b1, in_a[MAN_W-1:0]};
   assign sigB  = {1'b1, in_b[MAN_W-1:0]};
   assign signX = in_a[W-1] ^ in_b[W-1];

   // Handshake and result outputs decode straight from registered state
   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_result = result_q;
   assign out_flags  = flags_q;

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         man_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         man_q    <= man_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // Next-state logic: classify at accept, shift-add, normalise, round, hold
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      man_d    = man_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      result_d = result_q;
      flags_d  = flags_q;
      roundUp  = 1'b0;
      manSum   = '0;
      expR     = '0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d  = signX;
               exp_d   = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS_X;
               flags_d = '0;
               if (aNan | bNan | (aInf & bZero) | (aZero & bInf)) begin
                  result_d               = QNAN64[W-1:0];
                  flags_d[FLAG_INVALID]  = 1'b1;
                  state_d                = DONE;
               end else if (aInf | bInf) begin
                  result_d = {signX, ONES64[EXP_W-1:0], {MAN_W{1'b0}}};
                  state_d  = DONE;
               end else if (aZero | bZero) begin
                  result_d = {signX, {(W-1){1'b0}}};
                  state_d  = DONE;
               end else begin
                  // The accept cycle already performs the bit-0 partial product
                  acc_d    = sigB[0] ? {{SW{1'b0}}, sigA} : '0;
                  mcand_d  = {{(SW-1){1'b0}}, sigA, 1'b0};
                  mplier_d = sigB >> 1;
                  cnt_d    = CW'(1);
                  state_d  = MUL;
               end
            end
         end
         MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(MAN_W)) begin
               state_d = NORM;
            end
         end
         NORM: begin
            if (acc_q[PW-1]) begin
               man_d    = acc_q[PW-2 -: MAN_W];
               guard_d  = acc_q[PW-2-MAN_W];
               sticky_d = |acc_q[PW-3-MAN_W:0];
               exp_d    = exp_q + ONE_X;
            end else begin
               man_d    = acc_q[PW-3 -: MAN_W];
               guard_d  = acc_q[PW-3-MAN_W];
               sticky_d = |acc_q[PW-4-MAN_W:0];
            end
            state_d = RND;
         end
         RND: begin
`ifdef FP_MUL_RNE_EN
            roundUp = guard_q & (sticky_q | man_q[0]);
`else
            roundUp = 1'b0;
`endif
            manSum = {1'b0, man_q} + {{MAN_W{1'b0}}, roundUp};
            expR   = exp_q + (manSum[MAN_W] ? ONE_X : ZERO_X);
            flags_d = '0;
            if (expR >= MAXEXP_X) begin
               result_d                = {sign_q, ONES64[EXP_W-1:0], {MAN_W{1'b0}}};
               flags_d[FLAG_OVERFLOW]  = 1'b1;
               flags_d[FLAG_INEXACT]   = 1'b1;
            end else if (expR <= ZERO_X) begin
               result_d                = {sign_q, {(W-1){1'b0}}};
               flags_d[FLAG_UNDERFLOW] = 1'b1;
               flags_d[FLAG_INEXACT]   = 1'b1;
            end else begin
               result_d              = {sign_q, expR[EXP_W-1:0], manSum[MAN_W-1:0]};
               flags_d[FLAG_INEXACT] = guard_q | sticky_q;
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed and randomized checks of fp_mul_seq at default
// widths against an arithmetic reference model.
module tb_fp_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int checks = 0;
   int errors = 0;

   fp_mul_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Safety net against a hung handshake
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: exact integer product of the significands, then rounding by value
   task automatic refModel(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] fl, output int lat);
      logic [7:0]       ea, eb;
      logic [22:0]      fa, fb;
      logic             sgn, aNan, bNan, aInf, bInf, aZero, bZero, inexact;
      longint unsigned  sa, sb, prod, man, rem, half;
      int               e, sh;
      ea = a[30:23]; fa = a[22:0];
      eb = b[30:23]; fb = b[22:0];
      sgn   = a[31] ^ b[31];
      aNan  = (ea == 8'hFF) && (fa != 0);
      bNan  = (eb == 8'hFF) && (fb != 0);
      aInf  = (ea == 8'hFF) && (fa == 0);
      bInf  = (eb == 8'hFF) && (fb == 0);
      aZero = (ea == 8'h00);
      bZero = (eb == 8'h00);
      lat = 1;
      fl  = 4'b0000;
      if (aNan || bNan || (aInf && bZero) || (aZero && bInf)) begin
         r  = 32'h7FC00000;
         fl = 4'b1000;
      end else if (aInf || bInf) begin
         r = {sgn, 8'hFF, 23'h0};
      end else if (aZero || bZero) begin
         r = {sgn, 31'h0};
      end else begin
         lat  = 26;
         sa   = {1'b1, fa};
         sb   = {1'b1, fb};
         prod = sa * sb;
         e    = int'(ea) + int'(eb) - 127;
         if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
         end else begin
            sh = 23;
         end
         man     = prod >> sh;
         rem     = prod - (man << sh);
         half    = 64'd1 << (sh - 1);
         inexact = (rem != 0);
`ifdef FP_MUL_RNE_EN
         if (rem > half || (rem == half && man[0])) man = man + 1;
`endif
         if (man == (64'd1 << 24)) begin
            man = man >> 1;
            e   = e + 1;
         end
         if (e >= 255) begin
            r  = {sgn, 8'hFF, 23'h0};
            fl = 4'b0101;
         end else if (e <= 0) begin
            r  = {sgn, 31'h0};
            fl = 4'b0011;
         end else begin
            r  = {sgn, e[7:0], man[22:0]};
            fl = {3'b000, inexact};
         end
      end
   endtask

   // Present one operand pair, then wait (bounded) for out_valid without consuming it
   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [3:0] fl, output int lat);
      @(negedge clk);
      checkOutput({tag, ".inReadyIdle"}, in_ready, 1);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (out_valid !== 1'b1) checkOutput({tag, ".validTimeout"}, out_valid, 1);
      res = out_result;
      fl  = out_flags;
   endtask

   // Consume the pending result and confirm the block is ready again
   task automatic completeTransfer(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, ".validDropped"}, out_valid, 0);
      checkOutput({tag, ".inReadyAfter"}, in_ready, 1);
   endtask

   task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] expRes, input logic [3:0] expFl, input int expLat);
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      applyStimulus(tag, a, b, res, fl, lat);
      checkOutput({tag, ".result"}, res, expRes);
      checkOutput({tag, ".flags"}, fl, expFl);
      checkOutput({tag, ".latency"}, lat, expLat);
      completeTransfer(tag);
   endtask

   function automatic logic [31:0] randOperand();
      int unsigned pick;
      logic [7:0]  e;
      logic [22:0] f;
      pick = $urandom_range(0, 15);
      f    = 23'($urandom);
      case (pick)
         0:       begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = '0; end
         1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
         2, 3:    e = 8'($urandom_range(1, 30));
         4, 5:    e = 8'($urandom_range(225, 254));
         6:       f = (pick == 6) ? 23'h7FFFFF : f;
         default: e = 8'($urandom_range(100, 154));
      endcase
      if (pick == 6) e = 8'($urandom_range(120, 134));
      return {1'($urandom), e, f};
   endfunction

   initial begin
      logic [31:0] res, expRes, a, b;
      logic [3:0]  fl, expFl;
      int          lat, expLat, sawValid;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.outValid", out_valid, 0);
      checkOutput("reset.inReady", in_ready, 1);
      checkOutput("reset.outResult", out_result, 0);
      checkOutput("reset.outFlags", out_flags, 0);
      @(negedge clk);
      rst_n = 1'b1;

      runDirected("mul1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
      runDirected("infXzero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
      runDirected("negInfX1", 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 1);
      runDirected("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 26);
      runDirected("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 26);
`ifdef FP_MUL_RNE_EN
      runDirected("rounding", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001, 26);
`else
      runDirected("rounding", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 4'b0001, 26);
`endif
      runDirected("denormFtz", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1);
      runDirected("nanOperand", 32'h3F800000, 32'hFFC12345, 32'h7FC00000, 4'b1000, 1);

      // Backpressure: result must hold steady while out_ready stays low
      applyStimulus("backpressure", 32'h3FC00000, 32'h40000000, res, fl, lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("backpressure.outValid", out_valid, 1);
         checkOutput("backpressure.outResult", out_result, 32'h40400000);
         checkOutput("backpressure.inReady", in_ready, 0);
      end
      completeTransfer("backpressure");

      // Reset pulse mid-MUL aborts the operation and emits nothing
      @(negedge clk);
      in_a     = 32'h3FC00000;
      in_b     = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midReset.outValid", out_valid, 0);
      checkOutput("midReset.inReady", in_ready, 1);
      @(negedge clk);
      rst_n    = 1'b1;
      sawValid = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) sawValid = 1;
      end
      checkOutput("midReset.noEmit", sawValid, 0);
      runDirected("afterReset", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);

      // Randomized operands against the reference model
      for (int n = 0; n < 80; n++) begin
         a = randOperand();
         b = randOperand();
         refModel(a, b, expRes, expFl, expLat);
         applyStimulus($sformatf("rand%0d", n), a, b, res, fl, lat);
         checkOutput($sformatf("rand%0d.result a=%h b=%h", n, a, b), res, expRes);
         checkOutput($sformatf("rand%0d.flags a=%h b=%h", n, a, b), fl, expFl);
         checkOutput($sformatf("rand%0d.latency", n), lat, expLat);
         completeTransfer($sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
